target_pos_planner: RTL

Upstream command stage for the step/dir motor controller. It accepts absolute target positions over a valid/ready handshake and tracks the last commanded position. It converts each target into one or more relative move segments (`deltaPos`, `moveDir`, `velocityMaxIPS`), each announced by a one-cycle `newPosSignal` pulse that writes the controller's command FIFO. Segments are paced with a guard gap and held off while the downstream FIFO reports full.

---
 rtl/motor_pkg.sv | 22 ++
 rtl/vel_clamp.sv | 21 ++
 rtl/target_pos_planner.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared widths, default velocity limits and planner state encoding
package motor_pkg;

    localparam int VEL_W   = 20;
    localparam int DELTA_W = 16;

    localparam logic [VEL_W-1:0] DEF_MIN_VEL_IPS = 20'd100;
    localparam logic [VEL_W-1:0] DEF_MAX_VEL_IPS = 20'd200000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } planner_state_t;

    // Magnitude of a 33-bit two's complement difference; 2^32 still fits unsigned.
    function automatic logic [32:0] abs33(input logic [32:0] v);
        return v[32] ? (~v + 33'd1) : v;
    endfunction

endpackage

// File: rtl/vel_clamp.sv
// rtl/vel_clamp.sv - combinational velocity clamp, zero maps to the floor
module vel_clamp
    import motor_pkg::*;
#(
    parameter logic [VEL_W-1:0] MIN_VEL = DEF_MIN_VEL_IPS,
    parameter logic [VEL_W-1:0] MAX_VEL = DEF_MAX_VEL_IPS
) (
    input  logic [VEL_W-1:0] vel_in,
    output logic [VEL_W-1:0] vel_out
);

    always_comb begin
        vel_out = vel_in;
        if (vel_in == '0 || vel_in < MIN_VEL) begin
            vel_out = MIN_VEL;
        end else if (vel_in > MAX_VEL) begin
            vel_out = MAX_VEL;
        end
    end

endmodule

// File: rtl/target_pos_planner.sv
// rtl/target_pos_planner.sv - absolute target to paced relative segments; TARGET_POS_PLANNER_SOFT_LIMIT_EN adds target clamping
module target_pos_planner
    import motor_pkg::*;
#(
    parameter logic [DELTA_W-1:0] MAX_SEG     = 16'd4096,
    parameter int                 GAP_CYCLES  = 4,
    parameter logic [VEL_W-1:0]   MIN_VEL_IPS = DEF_MIN_VEL_IPS,
    parameter logic [VEL_W-1:0]   MAX_VEL_IPS = DEF_MAX_VEL_IPS,
    parameter logic signed [31:0] POS_MIN     = -32'sd1000000,
    parameter logic signed [31:0] POS_MAX     = 32'sd1000000
) (
    input  logic                      CLK_50MHZ,
    input  logic                      rst,
    input  logic signed [31:0]        targetPos,
    input  logic [VEL_W-1:0]          velocityIPS,
    input  logic                      targetValid,
    output logic                      targetReady,
    input  logic                      cmdFifoFull,
    output logic [DELTA_W-1:0]        deltaPos,
    output logic                      moveDir,
    output logic [VEL_W-1:0]          velocityMaxIPS,
    output logic                      newPosSignal,
    output logic signed [31:0]        cmdPosition,
    output logic                      busy,
    output logic                      limitHit
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);

    planner_state_t     state;
    logic signed [31:0] target_q;
    logic [VEL_W-1:0]   vel_q;
    logic [VEL_W-1:0]   vel_seg;
    logic [VEL_W-1:0]   vel_clamped;
    logic [32:0]        remaining;
    logic               dir_q;
    logic [15:0]        gap_cnt;
    logic signed [31:0] target_eff;
    logic               clamp_hit;
    logic [32:0]        diff;
    logic [DELTA_W-1:0] seg;
    logic               accept;

    vel_clamp #(
        .MIN_VEL (MIN_VEL_IPS),
        .MAX_VEL (MAX_VEL_IPS)
    ) u_vel_clamp (
        .vel_in  (vel_q),
        .vel_out (vel_clamped)
    );

`ifdef TARGET_POS_PLANNER_SOFT_LIMIT_EN
    always_comb begin
        target_eff = target_q;
        clamp_hit  = 1'b0;
        if (target_q < POS_MIN) begin
            target_eff = POS_MIN;
            clamp_hit  = 1'b1;
        end else if (target_q > POS_MAX) begin
            target_eff = POS_MAX;
            clamp_hit  = 1'b1;
        end
    end
`else
    logic limit_unused;
    assign limit_unused = ^{POS_MIN, POS_MAX};
    assign target_eff   = target_q;
    assign clamp_hit    = 1'b0;
`endif

    // 33-bit difference so any pair of 32-bit positions is representable.
    assign diff = {target_eff[31], target_eff} - {cmdPosition[31], cmdPosition};
    assign seg  = (remaining > {17'd0, MAX_SEG}) ? MAX_SEG : remaining[DELTA_W-1:0];

    assign targetReady = (state == ST_IDLE) && !rst;
    assign accept      = targetValid && targetReady;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge CLK_50MHZ) begin
        if (rst) begin
            state          <= ST_IDLE;
            target_q       <= '0;
            vel_q          <= '0;
            vel_seg        <= '0;
            remaining      <= '0;
            dir_q          <= 1'b0;
            gap_cnt        <= '0;
            deltaPos       <= '0;
            moveDir        <= 1'b0;
            velocityMaxIPS <= '0;
            newPosSignal   <= 1'b0;
            cmdPosition    <= '0;
            limitHit       <= 1'b0;
        end else begin
            newPosSignal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target_q <= targetPos;
                        vel_q    <= velocityIPS;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    remaining <= abs33(diff);
                    dir_q     <= ~diff[32];
                    vel_seg   <= vel_clamped;
                    if (clamp_hit) begin
                        limitHit <= 1'b1;
                    end
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (remaining == '0) begin
                        state <= ST_IDLE;
                    end else if (!cmdFifoFull) begin
                        deltaPos       <= seg;
                        moveDir        <= dir_q;
                        velocityMaxIPS <= vel_seg;
                        newPosSignal   <= 1'b1;
                        cmdPosition    <= dir_q ? cmdPosition + $signed({16'd0, seg})
                                                : cmdPosition - $signed({16'd0, seg});
                        remaining      <= remaining - {17'd0, seg};
                        gap_cnt        <= GAP_LOAD;
                        state          <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // GAP lasts GAP_CYCLES cycles, so pulses land GAP_CYCLES+1 apart.
                    if (gap_cnt <= 16'd1) begin
                        state <= ST_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
